// File: rtl/nibble_frame_loader.sv
// rtl/nibble_frame_loader.sv - packs 16 nibbles into a 64-bit frame for a 16-input adder tree
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   flush_i         drop the partial frame; a same-cycle transfer is ignored
//   in_valid_i      nibble offered
//   in_data_i[3:0]  nibble value
//   in_ready_o      nibble accepted when in_valid_i is also high
//   lanes_o[63:0]   committed frame, lane k on bits [4k+3:4k] (lane 0 = adder input a)
//   frame_valid_o   one-cycle pulse in the first cycle lanes_o shows a new frame
//   sum_valid_o     one-cycle pulse LATENCY cycles after frame_valid_o
//   fill_cnt_o[3:0] nibbles held in the partial frame
//   frame_cnt_o[7:0] committed frames, wrapping
//
// Build option: FRAME_LOADER_OVERLAP_EN - when defined the loader never stalls
// waiting for the adder; the next frame fills while the previous one is summed.
// When undefined only one frame is in flight at a time.

module nibble_frame_loader #(
  parameter int LATENCY = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  logic [3:0]  in_data_i,
  output logic        in_ready_o,
  output logic [63:0] lanes_o,
  output logic        frame_valid_o,
  output logic        sum_valid_o,
  output logic [3:0]  fill_cnt_o,
  output logic [7:0]  frame_cnt_o
);

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Low throughout reset and until the first edge after release, so that
  // in_ready_o only rises on a clock edge.
  logic live;

  // Lanes 0..14 of the partial frame; lane 15 is taken straight from the
  // 16th nibble when the frame commits.
  logic [59:0] work;

  logic [LATENCY-1:0] sum_sr;
  logic transfer;
  logic commit;

  assign in_ready_o  = live && (state == FILL);
  assign transfer    = in_valid_i && in_ready_o;
  assign commit      = transfer && !flush_i && (fill_cnt_o == 4'd15);
  assign sum_valid_o = sum_sr[LATENCY-1];

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
`ifdef FRAME_LOADER_OVERLAP_EN
        state_nxt = FILL;
`else
        if (commit) state_nxt = WAIT;
`endif
      end
      WAIT: begin
        if (sum_valid_o) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      live          <= 1'b0;
      work          <= '0;
      lanes_o       <= '0;
      frame_valid_o <= 1'b0;
      sum_sr        <= '0;
      fill_cnt_o    <= '0;
      frame_cnt_o   <= '0;
    end else begin
      live          <= 1'b1;
      state         <= state_nxt;
      frame_valid_o <= commit;

      // Delay line carrying each frame_valid_o pulse to the adder result.
      sum_sr[0] <= frame_valid_o;
      for (int i = 1; i < LATENCY; i++) begin
        sum_sr[i] <= sum_sr[i-1];
      end

      if (flush_i) begin
        fill_cnt_o <= '0;
      end else if (transfer) begin
        for (int k = 0; k < 15; k++) begin
          if (fill_cnt_o == 4'(k)) work[4*k +: 4] <= in_data_i;
        end
        // 15 + 1 wraps to 0, which is exactly the post-commit fill count.
        fill_cnt_o <= fill_cnt_o + 4'd1;
        if (commit) begin
          lanes_o     <= {in_data_i, work};
          frame_cnt_o <= frame_cnt_o + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_frame_loader.sv
// tb/tb_nibble_frame_loader.sv - self-checking bench for nibble_frame_loader

module tb_nibble_frame_loader;

  localparam int LATENCY = 5;
`ifdef FRAME_LOADER_OVERLAP_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = LATENCY + 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic [3:0]  in_data_i;
  logic        in_ready_o;
  logic [63:0] lanes_o;
  logic        frame_valid_o;
  logic        sum_valid_o;
  logic [3:0]  fill_cnt_o;
  logic [7:0]  frame_cnt_o;

  nibble_frame_loader #(.LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .lanes_o      (lanes_o),
    .frame_valid_o(frame_valid_o),
    .sum_valid_o  (sum_valid_o),
    .fill_cnt_o   (fill_cnt_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] lanes;
    int          cyc;
  } sb_t;

  sb_t         sb_q[$];
  int          fv_q[$];
  int          cyc = 0;
  logic [7:0]  exp_fc;
  logic [63:0] last_lanes;
  sb_t         mon_r;
  int          mon_fv;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: frames against the scoreboard, commit timing, counter, lane hold,
  // and sum_valid_o latency.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_frame_valid", 64'd1, 64'd0);
        end else begin
          mon_r = sb_q.pop_front();
          check("lanes", lanes_o, mon_r.lanes);
          check("fv_cycle", 64'(cyc), 64'(mon_r.cyc));
          exp_fc = exp_fc + 8'd1;
          check("frame_cnt", 64'(frame_cnt_o), 64'(exp_fc));
        end
        fv_q.push_back(cyc);
      end else begin
        check("lanes_hold", lanes_o, last_lanes);
      end
      last_lanes = lanes_o;
      if (sum_valid_o) begin
        if (fv_q.size() == 0) begin
          check("unexpected_sum_valid", 64'd1, 64'd0);
        end else begin
          mon_fv = fv_q.pop_front();
          check("sum_latency", 64'(cyc - mon_fv), 64'(LATENCY));
        end
      end
    end else begin
      last_lanes = '0;
    end
  end

  // Called at a negedge; leaves in_valid_i high so calls chain back to back.
  task automatic send_nibble(input logic [3:0] d, input bit last, input logic [63:0] exp,
                             output int stall);
    int waited;
    waited     = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    while (!in_ready_o && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    stall = waited;
    if (!in_ready_o) begin
      check("ready_timeout", 64'd0, 64'd1);
      in_valid_i = 1'b0;
      return;
    end
    if (last) sb_q.push_back('{exp, cyc + 1});
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] base, input logic [3:0] step, input bit gaps,
                            input logic [63:0] exp, output int first_stall);
    int st;
    logic [3:0] d;
    first_stall = 0;
    for (int n = 0; n < 16; n++) begin
      if (gaps && (n == 5 || n == 11)) begin
        in_valid_i = 1'b0;
        repeat (3) @(negedge clk);
      end
      d = base + step * 4'(n);
      send_nibble(d, n == 15, exp, st);
      if (n == 0) first_stall = st;
    end
  endtask

  typedef struct {
    logic [3:0]  base;
    logic [3:0]  step;
    bit          gaps;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [63:0] e;
    logic [3:0]  d;

    vecs[0] = '{4'h1, 4'h1, 1'b0, 64'h0FEDCBA987654321};
    vecs[1] = '{4'hF, 4'hF, 1'b0, 64'h0123456789ABCDEF};
    vecs[2] = '{4'h0, 4'h5, 1'b1, 64'hB61C72D83E94FA50};
    vecs[3] = '{4'h3, 4'h0, 1'b0, 64'h3333333333333333};

    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
    exp_fc = '0; last_lanes = '0;
    repeat (3) @(negedge clk);
    check("rst_lanes", lanes_o, 64'd0);
    check("rst_fill", 64'(fill_cnt_o), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt_o), 64'd0);
    check("rst_fv", 64'(frame_valid_o), 64'd0);
    check("rst_sv", 64'(sum_valid_o), 64'd0);
    check("rst_ready", 64'(in_ready_o), 64'd0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", 64'(in_ready_o), 64'd0);
    @(negedge clk);
    check("ready_after_edge", 64'(in_ready_o), 64'd1);

    // Back-to-back frames with in_valid_i held high; stall on each new frame.
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].base, vecs[i].step, vecs[i].gaps, vecs[i].exp, st);
      if (i > 0) check("first_stall", 64'(st), 64'(EXP_STALL));
      check("fill_after_commit", 64'(fill_cnt_o), 64'd0);
    end
    in_valid_i = 1'b0;

    // Partial frame survives a pause, then a flush with a live transfer.
    for (int n = 0; n < 7; n++) send_nibble(4'h9, 1'b0, 64'd0, st);
    in_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    check("fill_retained", 64'(fill_cnt_o), 64'd7);
    in_valid_i = 1'b1; in_data_i = 4'hA; flush_i = 1'b1;
    check("ready_at_flush", 64'(in_ready_o), 64'd1);
    @(negedge clk);
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("fill_after_flush", 64'(fill_cnt_o), 64'd0);
    send_frame(4'h3, 4'h0, 1'b0, 64'h3333333333333333, st);
    in_valid_i = 1'b0;
    repeat (LATENCY + 2) @(negedge clk);

    // Flush coinciding with the 16th nibble: no commit.
    for (int n = 0; n < 15; n++) send_nibble(4'h5, 1'b0, 64'd0, st);
    in_valid_i = 1'b1; in_data_i = 4'h5; flush_i = 1'b1;
    check("ready_at_flush16", 64'(in_ready_o), 64'd1);
    @(negedge clk);
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("fill_after_flush16", 64'(fill_cnt_o), 64'd0);
    repeat (LATENCY + 2) @(negedge clk);
    check("frame_cnt_no_commit", 64'(frame_cnt_o), 64'(exp_fc));

    // Reset two cycles after frame_valid_o: the sum pulse must never appear.
    send_frame(4'h1, 4'h1, 1'b0, 64'h0FEDCBA987654321, st);
    in_valid_i = 1'b0;
    check("fv_before_reset", 64'(frame_valid_o), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete(); fv_q.delete(); exp_fc = '0;
    for (int c = 0; c < LATENCY + 3; c++) begin
      @(negedge clk);
      check("rst_mid_sv", 64'(sum_valid_o), 64'd0);
    end
    check("rst_mid_lanes", lanes_o, 64'd0);
    check("rst_mid_fill", 64'(fill_cnt_o), 64'd0);
    check("rst_mid_frame_cnt", 64'(frame_cnt_o), 64'd0);
    check("rst_mid_fv", 64'(frame_valid_o), 64'd0);
    check("rst_mid_ready", 64'(in_ready_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 256 random frames: counter wraps back to 0.
    for (int f = 0; f < 256; f++) begin
      e = '0;
      for (int n = 0; n < 16; n++) begin
        d = 4'($urandom_range(0, 15));
        e[4*n +: 4] = d;
        send_nibble(d, n == 15, e, st);
      end
    end
    in_valid_i = 1'b0;
    repeat (LATENCY + 3) @(negedge clk);
    check("frame_cnt_wrap", 64'(frame_cnt_o), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("sum_drained", 64'(fv_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
